bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 27 ++
 rtl/bus_arbiter.sv | 120 ++++++++++++
 tb/tb_bus_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/grant bus bundle between four masters and the arbiter
// The master modport is the requester side; the slave modport is the arbiter side.
interface bus_arbiter_if #(
   parameter int WIDTH = 32
);
   logic [3:0]       req;
   logic [WIDTH-1:0] m0_data;
   logic [WIDTH-1:0] m1_data;
   logic [WIDTH-1:0] m2_data;
   logic [WIDTH-1:0] m3_data;
   logic             bus_ready;
   logic [3:0]       gnt;
   logic [1:0]       sel;
   logic [WIDTH-1:0] bus_out;
   logic             busy;
   logic             timeout;

   modport master (
      output req, m0_data, m1_data, m2_data, m3_data, bus_ready,
      input  gnt, sel, bus_out, busy, timeout
   );

   modport slave (
      input  req, m0_data, m1_data, m2_data, m3_data, bus_ready,
      output gnt, sel, bus_out, busy, timeout
   );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - four-master round-robin arbiter with per-grant ready timeout
// A release re-arbitrates in the same edge, so back-to-back grants have no idle bubble.
module bus_arbiter #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          reset,
   bus_arbiter_if.slave  bi
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [3:0]    gnt_q, gnt_d;
   logic [1:0]    sel_q, sel_d;
   logic          busy_q, busy_d;
   logic          timeout_q, timeout_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    last_q, last_d;

   logic [1:0]    ptr;
   logic [1:0]    cand;
   logic [1:0]    win;
   logic          found;
   logic          cnt_done;
   logic          release_ev;
   logic [WIDTH-1:0] bus_out_w;

   // In GRANT the pointer used for re-arbitration is the master being released.
   assign ptr        = (state_q == GRANT) ? sel_q : last_q;
   assign cnt_done   = (cnt_q == CNT_MAX);
   assign release_ev = bi.bus_ready || !bi.req[sel_q] || cnt_done;

   always_comb begin
      found = 1'b0;
      win   = 2'd0;
      cand  = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         cand = ptr + 2'(i);
         if (!found && bi.req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      sel_d     = sel_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;
      cnt_d     = cnt_q;
      last_d    = last_q;
      if (state_q == IDLE) begin
         if (found) begin
            state_d = GRANT;
            gnt_d   = 4'b0001 << win;
            sel_d   = win;
            busy_d  = 1'b1;
            cnt_d   = '0;
         end
      end else if (release_ev) begin
         last_d    = sel_q;
         // Ready and a dropped request both take precedence over the counter.
         timeout_d = !bi.bus_ready && bi.req[sel_q] && cnt_done;
         if (found) begin
            gnt_d = 4'b0001 << win;
            sel_d = win;
            cnt_d = '0;
         end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         gnt_q     <= 4'b0000;
         sel_q     <= 2'd0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
         last_q    <= 2'd3;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         sel_q     <= sel_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
      end
   end

   always_comb begin
      case (sel_q)
         2'd0:    bus_out_w = bi.m0_data;
         2'd1:    bus_out_w = bi.m1_data;
         2'd2:    bus_out_w = bi.m2_data;
         default: bus_out_w = bi.m3_data;
      endcase
   end

   assign bi.gnt     = gnt_q;
   assign bi.sel     = sel_q;
   assign bi.busy    = busy_q;
   assign bi.timeout = timeout_q;
   assign bi.bus_out = bus_out_w;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized bench for bus_arbiter against a round-robin reference model
// The model tracks owner/pointer/wait as integers and applies the grant rules once per edge.
module tb_bus_arbiter;
   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic reset;

   bus_arbiter_if #(.WIDTH(WIDTH)) bif ();

   bus_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bi    (bif.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   int m_busy;
   int m_owner;
   int m_last;
   int m_wait;
   int m_to;
   int to_seen;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int pick(input int ptr, input logic [3:0] r);
      for (int i = 1; i <= 4; i++) begin
         if (r[(ptr + i) % 4]) return (ptr + i) % 4;
      end
      return -1;
   endfunction

   function automatic logic [WIDTH-1:0] data_of(input int idx);
      case (idx)
         0:       return bif.m0_data;
         1:       return bif.m1_data;
         2:       return bif.m2_data;
         default: return bif.m3_data;
      endcase
   endfunction

   task automatic model_edge();
      int w;
      bit rel;
      if (reset) begin
         m_busy = 0; m_owner = 0; m_last = 3; m_wait = 0; m_to = 0;
         return;
      end
      m_to = 0;
      if (m_busy == 0) begin
         w = pick(m_last, bif.req);
         if (w >= 0) begin
            m_busy = 1; m_owner = w; m_wait = 0;
         end
      end else begin
         rel = bif.bus_ready || !bif.req[m_owner] || (m_wait == TIMEOUT - 1);
         if (rel) begin
            m_to   = (!bif.bus_ready && bif.req[m_owner] && m_wait == TIMEOUT - 1) ? 1 : 0;
            m_last = m_owner;
            w = pick(m_last, bif.req);
            if (w >= 0) begin
               m_owner = w; m_wait = 0;
            end else begin
               m_busy = 0; m_wait = 0;
            end
         end else begin
            m_wait++;
         end
      end
   endtask

   task automatic check_model();
      check_eq("gnt", bif.gnt, m_busy ? (64'd1 << m_owner) : 64'd0);
      check_eq("sel", bif.sel, m_owner);
      check_eq("busy", bif.busy, m_busy);
      check_eq("timeout", bif.timeout, m_to);
      check_eq("bus_out", bif.bus_out, data_of(m_owner));
      if (bif.timeout === 1'b1) to_seen++;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic drive(input logic r, input logic [3:0] q, input logic rdy);
      reset         = r;
      bif.req       = q;
      bif.bus_ready = rdy;
   endtask

   int tmo_cycles;

   initial begin
      drive(1'b1, 4'b0000, 1'b0);
      bif.m0_data = 32'h0000_1000;
      bif.m1_data = 32'h1111_2000;
      bif.m2_data = 32'h2222_3000;
      bif.m3_data = 32'h3333_4000;
      m_busy = 0; m_owner = 0; m_last = 3; m_wait = 0; m_to = 0;
      to_seen = 0;
      step();
      step();

      // reset state, then two-requester handoff without an idle cycle
      drive(1'b0, 4'b0110, 1'b0);
      step();
      check_eq("req031_gnt", bif.gnt, 4'b0010);
      check_eq("req031_sel", bif.sel, 2'd1);
      bif.bus_ready = 1'b1;
      step();
      check_eq("req031_handoff", bif.gnt, 4'b0100);
      bif.bus_ready = 1'b0;
      step();

      // all requesting, ready every cycle: rotation
      drive(1'b1, 4'b1111, 1'b1);
      step();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("rotation", bif.gnt, 4'b0001 << (i % 4));
      end

      // single requester timing out and being regranted
      drive(1'b1, 4'b0001, 1'b0);
      step();
      reset = 1'b0;
      to_seen = 0;
      tmo_cycles = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (bif.gnt === 4'b0001 && bif.timeout === 1'b0) tmo_cycles++;
      end
      check_eq("tmo_hold_cycles", tmo_cycles, 16);
      step();
      check_eq("tmo_pulse", bif.timeout, 1'b1);
      check_eq("tmo_regrant", bif.gnt, 4'b0001);
      step();
      check_eq("tmo_pulse_one_cycle", bif.timeout, 1'b0);

      // granted master drops its request
      drive(1'b1, 4'b0100, 1'b0);
      step();
      reset = 1'b0;
      step();
      check_eq("drop_pre", bif.gnt, 4'b0100);
      bif.req = 4'b1000;
      step();
      check_eq("drop_gnt", bif.gnt, 4'b1000);
      check_eq("drop_sel", bif.sel, 2'd3);
      check_eq("drop_to", bif.timeout, 1'b0);

      // combinational bus_out follows m3 even after going idle
      bif.m3_data = 32'hDEAD_BEEF;
      #1;
      check_eq("bus_out_same_cycle", bif.bus_out, 32'hDEAD_BEEF);
      bif.req = 4'b0000;
      bif.bus_ready = 1'b1;
      step();
      check_eq("idle_busy", bif.busy, 1'b0);
      bif.m3_data = 32'h0BAD_F00D;
      #1;
      check_eq("idle_bus_out", bif.bus_out, 32'h0BAD_F00D);

      // reset mid-grant
      drive(1'b0, 4'b0100, 1'b0);
      step();
      step();
      reset = 1'b1;
      step();
      check_eq("rst_gnt", bif.gnt, 4'b0000);
      drive(1'b0, 4'b1001, 1'b0);
      step();
      check_eq("rst_regrant", bif.gnt, 4'b0001);

      // randomized traffic: two ready densities to exercise both completion and timeout
      for (int i = 0; i < 1200; i++) begin
         if ($urandom_range(0, 7) == 0) bif.req = 4'($urandom);
         bif.bus_ready = (i < 600) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
         reset = ($urandom_range(0, 99) == 0);
         bif.m0_data = $urandom;
         bif.m1_data = $urandom;
         bif.m2_data = $urandom;
         bif.m3_data = $urandom;
         #1;
         check_eq("bus_out_comb", bif.bus_out, data_of(m_owner));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
